pe_link_prober: RTL



---
 rtl/pe_link_prober.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/pe_link_prober.sv
// Link-test initiator: drives a numbered word sequence toward a loopback PE,
// checks the echo, and reports error count and round-trip latency.
// Optional macro PE_LINK_PROBER_STALL_EN: periodic ap_start stalls plus duplicate filtering.
module pe_link_prober #(
   parameter int WIDTH     = 130,
   parameter int NUM_WORDS = 256,
   parameter int TIMEOUT   = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [WIDTH-1:0] out_to_pe,
   output logic             out_start,
   input  logic [WIDTH-1:0] in_from_pe,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      err_count,
   output logic [7:0]       latency
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_SEND,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [16:0] NW17     = 17'(NUM_WORDS);
   localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);
   localparam logic [7:0]  TO8      = 8'(TIMEOUT);

   // Marker in the MSB, sequence number low, inverted sequence number repeated in between.
   function automatic logic [WIDTH-1:0] makeWord(input logic [15:0] k);
      logic [WIDTH-1:0] w;
      w = '0;
      w[15:0] = k;
      for (int i = 16; i < WIDTH - 1; i++) begin
         w[i] = ~k[4'((i - 16) % 16)];
      end
      w[WIDTH-1] = 1'b1;
      return w;
   endfunction

   state_t           r_state;
   state_t           w_nextState;
   logic             r_flushCnt;
   logic [15:0]      r_txIdx;
   logic [16:0]      r_rxIdx;
   logic [7:0]       r_idleCnt;
   logic [7:0]       r_latCnt;
   logic             r_latRun;
   logic [15:0]      r_errCount;
   logic [7:0]       r_latency;
   logic [WIDTH-1:0] r_outToPe;
   logic             r_outStart;

   logic             w_rxWindow;
   logic             w_marker;
   logic             w_accept;
   logic             w_idleReset;
   logic             w_mismatch;
   logic [16:0]      w_rxNext;
   logic [7:0]       w_idleNext;
   logic             w_rxComplete;
   logic             w_timeout;
   logic             w_sendLast;
   logic             w_nextStall;
   logic             w_runStart;
   logic [16:0]      w_missing;
   logic [16:0]      w_errPlusMissing;
   logic [16:0]      w_errPlusOne;
   logic [WIDTH-1:0] w_expWord;

`ifdef PE_LINK_PROBER_STALL_EN
   logic [1:0]       r_sendCyc;
   logic [1:0]       w_nextCyc;
   logic [15:0]      r_lastSeq;
   logic             r_haveLast;
   logic             w_dup;
`endif

   // Receive-side qualification, shared by the FSM and the datapath.
   always_comb begin
      w_rxWindow = (r_state == S_SEND) || (r_state == S_DRAIN);
      w_marker   = in_from_pe[WIDTH-1];
`ifdef PE_LINK_PROBER_STALL_EN
      w_dup       = r_haveLast && (in_from_pe[15:0] == r_lastSeq);
      w_idleReset = w_marker && !w_dup;
      w_accept    = w_rxWindow && w_marker && !w_dup && (r_rxIdx < NW17);
      w_nextCyc   = (r_state == S_SEND) ? r_sendCyc + 2'd1 : 2'd0;
`else
      w_idleReset = w_marker;
      w_accept    = w_rxWindow && w_marker && (r_rxIdx < NW17);
`endif
      w_expWord    = makeWord(r_rxIdx[15:0]);
      w_mismatch   = w_accept && (in_from_pe != w_expWord);
      w_rxNext     = r_rxIdx + 17'(w_accept);
      w_idleNext   = w_idleReset ? 8'd0 : r_idleCnt + 8'd1;
      w_rxComplete = (w_rxNext == NW17);
      w_timeout    = (w_idleNext == TO8);
      w_sendLast   = (r_state == S_SEND) && (r_txIdx == LAST_IDX);
      w_runStart   = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
      w_missing        = NW17 - w_rxNext;
      w_errPlusMissing = {1'b0, r_errCount} + w_missing;
      w_errPlusOne     = {1'b0, r_errCount} + 17'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:  if (start) w_nextState = S_FLUSH;
         S_FLUSH: if (r_flushCnt) w_nextState = S_SEND;
         S_SEND:  if (w_sendLast) w_nextState = S_DRAIN;
         S_DRAIN: if (w_rxComplete || w_timeout) w_nextState = S_DONE;
         S_DONE:  if (start) w_nextState = S_FLUSH;
         default: w_nextState = S_IDLE;
      endcase
   end

   always_comb begin
      w_nextStall = 1'b0;
`ifdef PE_LINK_PROBER_STALL_EN
      w_nextStall = (w_nextState == S_SEND) && (w_nextCyc == 2'b11);
`endif
   end

   // Transmit path, receiver bookkeeping and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_flushCnt <= 1'b0;
         r_txIdx    <= '0;
         r_rxIdx    <= '0;
         r_idleCnt  <= '0;
         r_latCnt   <= '0;
         r_latRun   <= 1'b0;
         r_errCount <= '0;
         r_latency  <= 8'hFF;
         r_outToPe  <= '0;
         r_outStart <= 1'b0;
`ifdef PE_LINK_PROBER_STALL_EN
         r_sendCyc  <= '0;
         r_lastSeq  <= '0;
         r_haveLast <= 1'b0;
`endif
      end else begin
         r_outStart <= ((w_nextState == S_FLUSH) || (w_nextState == S_SEND) ||
                        (w_nextState == S_DRAIN)) && !w_nextStall;

         if (r_latRun && (r_latCnt != 8'hFF)) begin
            r_latCnt <= r_latCnt + 8'd1;
         end

         if (w_runStart) begin
            r_errCount <= '0;
            r_rxIdx    <= '0;
            r_latency  <= 8'hFF;
            r_latRun   <= 1'b0;
            r_flushCnt <= 1'b0;
            r_idleCnt  <= '0;
            r_outToPe  <= '0;
`ifdef PE_LINK_PROBER_STALL_EN
            r_haveLast <= 1'b0;
`endif
         end

         case (r_state)
            S_FLUSH: begin
               r_flushCnt <= 1'b1;
               if (r_flushCnt) begin
                  r_outToPe <= makeWord(16'd0);
                  r_txIdx   <= '0;
                  r_latCnt  <= '0;
                  r_latRun  <= 1'b1;
`ifdef PE_LINK_PROBER_STALL_EN
                  r_sendCyc <= '0;
`endif
               end
            end
            S_SEND: begin
`ifdef PE_LINK_PROBER_STALL_EN
               r_sendCyc <= w_nextCyc;
`endif
               if (w_sendLast) begin
                  r_outToPe <= '0;
                  r_idleCnt <= '0;
               end else if (!w_nextStall) begin
                  r_txIdx   <= r_txIdx + 16'd1;
                  r_outToPe <= makeWord(r_txIdx + 16'd1);
               end
            end
            S_DRAIN: begin
               r_idleCnt <= w_idleNext;
               if (w_timeout && !w_rxComplete) begin
                  r_errCount <= w_errPlusMissing[16] ? 16'hFFFF : w_errPlusMissing[15:0];
               end
            end
            default: ;
         endcase

         // A received word counts even on the cycle the FSM leaves SEND or DRAIN.
         if (w_accept) begin
            r_rxIdx <= w_rxNext;
            if (w_mismatch) begin
               r_errCount <= w_errPlusOne[16] ? 16'hFFFF : w_errPlusOne[15:0];
            end
            if (r_latRun) begin
               r_latency <= r_latCnt;
               r_latRun  <= 1'b0;
            end
`ifdef PE_LINK_PROBER_STALL_EN
            r_lastSeq  <= in_from_pe[15:0];
            r_haveLast <= 1'b1;
`endif
         end
      end
   end

   assign out_to_pe = r_outToPe;
   assign out_start = r_outStart;
   assign busy      = (r_state == S_FLUSH) || (r_state == S_SEND) || (r_state == S_DRAIN);
   assign done      = (r_state == S_DONE);
   assign pass      = done && (r_errCount == 16'd0);
   assign err_count = r_errCount;
   assign latency   = r_latency;

endmodule
